// File: rtl/slow_to_fast_sync.sv
// Captures words launched on a slow, asynchronous clock level into the fast
// domain, checks them for stability and queues them in a 2-entry buffer.
module slow_to_fast_sync #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_RETRY   = 3
) (
  input  logic             fast_clk,
  input  logic             reset,
  input  logic             slow_clk_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             q_glitch,
  output logic             overrun
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  localparam int LAST = SYNC_STAGES - 1;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CHECK
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] seen;
  logic                   hist;
  logic                   armed;
  logic                   rise;

  // armed needs a genuine low sample after reset, so a level that was
  // already high at release cannot masquerade as a rising edge.
  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      seen  <= '0;
      hist  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], slow_clk_in};
      seen <= {seen[SYNC_STAGES-2:0], 1'b1};
      hist <= sync[LAST];
      if (seen[LAST] && !sync[LAST]) begin
        armed <= 1'b1;
      end
    end
  end

  assign rise = sync[LAST] & ~hist & armed;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_n;
  logic [RW-1:0]    retry;
  logic [RW-1:0]    retry_n;
  logic             push;
  logic             push_glitch;
  logic [WIDTH-1:0] push_data;

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      shadow <= '0;
      retry  <= '0;
    end else begin
      state  <= state_n;
      shadow <= shadow_n;
      retry  <= retry_n;
    end
  end

  always_comb begin
    state_n     = state;
    shadow_n    = shadow;
    retry_n     = retry;
    push        = 1'b0;
    push_data   = shadow;
    push_glitch = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n = SAMPLE;
        end
      end
      SAMPLE: begin
        shadow_n = d;
        retry_n  = '0;
        state_n  = CHECK;
      end
      CHECK: begin
        if (d == shadow) begin
          push    = 1'b1;
          state_n = IDLE;
        end else if (retry < RMAX) begin
          shadow_n = d;
          retry_n  = retry + 1'b1;
        end else begin
          push        = 1'b1;
          push_data   = d;
          push_glitch = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic [WIDTH:0] mem [2];
  logic           rd_ptr;
  logic [1:0]     cnt;
  logic           pop;
  logic           full;
  logic           push_ok;
  logic           wr_idx;

  assign pop     = (cnt != 2'd0) & q_ready;
  assign full    = (cnt == 2'd2);
  assign push_ok = push & (~full | pop);
  // When full, the slot being popped is the one at rd_ptr.
  assign wr_idx  = rd_ptr ^ cnt[0];

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      rd_ptr  <= 1'b0;
      cnt     <= 2'd0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_idx] <= {push_glitch, push_data};
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, push_ok} - {1'b0, pop};
      if (push && full && !pop) begin
        overrun <= 1'b1;
      end
    end
  end

  assign q_valid  = (cnt != 2'd0);
  assign q        = q_valid ? mem[rd_ptr][WIDTH-1:0] : '0;
  assign q_glitch = q_valid & mem[rd_ptr][WIDTH];

endmodule

// File: tb/tb_slow_to_fast_sync.sv
// Bench for slow_to_fast_sync: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_slow_to_fast_sync;

  logic        fast_clk;
  logic        reset;
  logic        slow_clk_in;
  logic [11:0] d;
  logic [11:0] q;
  logic        q_valid;
  logic        q_ready;
  logic        q_glitch;
  logic        overrun;

  slow_to_fast_sync #(
    .WIDTH(12),
    .SYNC_STAGES(2),
    .MAX_RETRY(3)
  ) dut (
    .fast_clk(fast_clk),
    .reset(reset),
    .slow_clk_in(slow_clk_in),
    .d(d),
    .q(q),
    .q_valid(q_valid),
    .q_ready(q_ready),
    .q_glitch(q_glitch),
    .overrun(overrun)
  );

  initial fast_clk = 1'b0;
  always #5 fast_clk = ~fast_clk;

  int n_assert = 0;
  int n_fail = 0;

  logic [12:0] mq[$];
  bit ovr;
  bit pend_valid;
  bit pend_glitch;
  bit last_sample;
  bit exp_glitch;
  bit rnd_ready;
  int cyc;
  int pend_edge;
  int extra;
  int vld_cnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_edge();
    bit pop;
    pop = (mq.size() != 0) && q_ready;
    if (pop) void'(mq.pop_front());
    if (pend_valid && cyc == pend_edge) begin
      pend_valid = 1'b0;
      if (mq.size() < 2) mq.push_back({pend_glitch, d});
      else ovr = 1'b1;
    end
    if (slow_clk_in && !last_sample && !pend_valid) begin
      pend_valid  = 1'b1;
      pend_edge   = cyc + 4 + extra;
      pend_glitch = exp_glitch;
    end
    last_sample = slow_clk_in;
  endtask

  task automatic check_outputs();
    logic [11:0] eq;
    logic        eg;
    eq = (mq.size() != 0) ? mq[0][11:0] : 12'h000;
    eg = (mq.size() != 0) ? mq[0][12] : 1'b0;
    chk("q_valid", 32'(q_valid), 32'(mq.size() != 0));
    chk("q", 32'(q), 32'(eq));
    chk("q_glitch", 32'(q_glitch), 32'(eg));
    chk("overrun", 32'(overrun), 32'(ovr));
  endtask

  task automatic tick();
    @(posedge fast_clk);
    cyc++;
    model_edge();
    #1;
    check_outputs();
    if (q_valid) vld_cnt++;
    if (rnd_ready) q_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_q_valid", 32'(q_valid), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_q_glitch", 32'(q_glitch), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    repeat (2) @(posedge fast_clk);
    #3;
    reset = 1'b0;
    mq.delete();
    ovr = 1'b0;
    pend_valid = 1'b0;
    last_sample = 1'b1;
  endtask

  task automatic slow_pulse(input logic [11:0] val, input int hi,
                            input int lo);
    d = val;
    slow_clk_in = 1'b1;
    hold(hi);
    slow_clk_in = 1'b0;
    hold(lo);
  endtask

  initial begin
    reset = 1'b0;
    slow_clk_in = 1'b0;
    d = 12'h000;
    q_ready = 1'b0;
    rnd_ready = 1'b0;
    extra = 0;
    exp_glitch = 1'b0;
    cyc = 0;
    vld_cnt = 0;
    do_reset();
    hold(5);

    q_ready = 1'b1;
    vld_cnt = 0;
    repeat (3) slow_pulse(12'h0FF, 50, 50);
    chk("one_pulse_per_period", 32'(vld_cnt), 32'd3);

    q_ready = 1'b0;
    slow_pulse(12'h001, 10, 10);
    slow_pulse(12'h002, 10, 10);
    slow_pulse(12'h003, 10, 10);
    chk("full_overrun", 32'(overrun), 32'd1);
    chk("full_head", 32'(q), 32'h001);
    q_ready = 1'b1;
    hold(4);
    do_reset();
    hold(5);

    extra = 3;
    exp_glitch = 1'b1;
    d = 12'hA5A;
    slow_clk_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      d = (d == 12'hA5A) ? 12'h5A5 : 12'hA5A;
    end
    hold(4);
    slow_clk_in = 1'b0;
    hold(15);
    extra = 0;
    exp_glitch = 1'b0;

    extra = 1;
    d = 12'h777;
    slow_clk_in = 1'b1;
    hold(4);
    d = 12'h123;
    hold(10);
    slow_clk_in = 1'b0;
    hold(15);
    extra = 0;

    d = 12'h456;
    slow_clk_in = 1'b1;
    hold(3);
    do_reset();
    hold(10);
    slow_clk_in = 1'b0;
    hold(10);
    slow_pulse(12'h456, 12, 12);

    q_ready = 1'b0;
    slow_pulse(12'($urandom), 10, 10);
    slow_pulse(12'($urandom), 10, 10);
    d = 12'($urandom);
    slow_clk_in = 1'b1;
    hold(4);
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
    hold(9);
    slow_clk_in = 1'b0;
    hold(10);
    chk("pushpop_full_overrun", 32'(overrun), 32'd0);
    q_ready = 1'b1;
    hold(4);

    rnd_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      slow_pulse(12'($urandom), $urandom_range(8, 30),
                 $urandom_range(8, 30));
    end
    rnd_ready = 1'b0;
    q_ready = 1'b1;
    hold(5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
